// File: rtl/pb_ctrl_pkg.sv
// Shared types and constants for the push-button command path.
package pb_ctrl_pkg;

   localparam logic PB_IDLE = 1'b1;

   typedef struct packed {
      logic [2:0] id;
      logic       lng;
   } pb_cmd_t;

endpackage

// File: rtl/pb_sync_rel.sv
// One button: 3-flop synchronizer, release pulse and, with PB_LONG_PRESS_EN,
// a saturating hold counter that flags a long press at release time.
module pb_sync_rel
   import pb_ctrl_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic PB,
   output logic rel,
   output logic lng
);

   logic s1, s2, s3;

   if (HOLD_CYCLES == 0) begin : g_bad_hold
      $error("pb_sync_rel: HOLD_CYCLES must be nonzero");
   end

   // Reset to idle level so leaving reset never looks like a release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= PB_IDLE;
         s2 <= PB_IDLE;
         s3 <= PB_IDLE;
      end else begin
         s1 <= PB;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rel = s2 & ~s3;

`ifdef PB_LONG_PRESS_EN
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

   logic [HOLD_W-1:0] hold;

   // Counter still holds the press length during the release cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold <= '0;
      end else if (s2) begin
         hold <= '0;
      end else if (hold != HOLD_W'(HOLD_CYCLES)) begin
         hold <= hold + HOLD_W'(1);
      end
   end

   assign lng = (hold == HOLD_W'(HOLD_CYCLES));
`else
   assign lng = 1'b0;
`endif

endmodule

// File: rtl/pb_cmd_arb.sv
// Push-button release arbiter: one pending event per button, round-robin onto a
// single valid/ready command channel. Long-press tagging under PB_LONG_PRESS_EN.
module pb_cmd_arb
   import pb_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PB      = 4,
   parameter int unsigned HOLD_CYCLES = 25_000_000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_PB-1:0]         PB,
   input  logic                      cmd_rdy,
   output logic                      cmd_vld,
   output logic [$clog2(NUM_PB)-1:0] cmd_id,
   output logic                      cmd_long,
   output logic                      ovf
);

   localparam int unsigned ID_W = $clog2(NUM_PB);

   logic [NUM_PB-1:0] rel;
   logic [NUM_PB-1:0] lng;
   logic [NUM_PB-1:0] pend;
   logic [NUM_PB-1:0] pend_long;
   logic [ID_W-1:0]   ptr;
   pb_cmd_t           cmd_q;

   logic              gnt_vld;
   logic [ID_W-1:0]   gnt_idx;
   logic [NUM_PB-1:0] gnt_mask;
   logic [ID_W-1:0]   cand;
   logic [ID_W-1:0]   ptr_nxt;

   if (NUM_PB < 2 || NUM_PB > 8) begin : g_bad_num
      $error("pb_cmd_arb: NUM_PB must be 2..8");
   end

   for (genvar g = 0; g < NUM_PB; g++) begin : g_pb
      pb_sync_rel #(
         .HOLD_CYCLES (HOLD_CYCLES)
      ) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .PB    (PB[g]),
         .rel   (rel[g]),
         .lng   (lng[g])
      );
   end

   // Round-robin search from ptr; only when the output register can load.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      gnt_mask = '0;
      cand     = '0;
      if (!cmd_vld || cmd_rdy) begin
         for (int unsigned k = 0; k < NUM_PB; k++) begin
            cand = ID_W'((32'(ptr) + k) % NUM_PB);
            if (!gnt_vld && pend[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      if (gnt_vld) begin
         gnt_mask[gnt_idx] = 1'b1;
      end
      ptr_nxt = (gnt_idx == ID_W'(NUM_PB - 1)) ? '0 : gnt_idx + ID_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend      <= '0;
         pend_long <= '0;
         ptr       <= '0;
         cmd_vld   <= 1'b0;
         cmd_q     <= '0;
         ovf       <= 1'b0;
      end else begin
         // A release coinciding with its own grant becomes the next event.
         for (int unsigned i = 0; i < NUM_PB; i++) begin
            if (rel[i] && (!pend[i] || gnt_mask[i])) begin
               pend[i]      <= 1'b1;
               pend_long[i] <= lng[i];
            end else if (gnt_mask[i]) begin
               pend[i] <= 1'b0;
            end
         end
         ovf <= |(rel & pend & ~gnt_mask);
         if (gnt_vld) begin
            cmd_vld   <= 1'b1;
            cmd_q.id  <= 3'(gnt_idx);
            cmd_q.lng <= pend_long[gnt_idx];
            ptr       <= ptr_nxt;
         end else if (cmd_rdy) begin
            cmd_vld <= 1'b0;
         end
      end
   end

   assign cmd_id   = cmd_q.id[ID_W-1:0];
   assign cmd_long = cmd_q.lng;

   if (ID_W < 3) begin : g_id_pad
      logic unused_id_bits;
      assign unused_id_bits = &{1'b0, cmd_q.id[2:ID_W]};
   end

endmodule

// File: tb/tb_pb_cmd_arb.sv
// Scoreboard bench for pb_cmd_arb (NUM_PB=4, HOLD_CYCLES=8); expectations
// follow PB_LONG_PRESS_EN when it is defined.
module tb_pb_cmd_arb;

   localparam int unsigned NUM_PB      = 4;
   localparam int unsigned HOLD_CYCLES = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] PB = 4'hF;
   logic       cmd_rdy = 1'b0;
   logic       cmd_vld;
   logic [1:0] cmd_id;
   logic       cmd_long;
   logic       ovf;

   typedef struct {
      int unsigned id;
      bit          lng;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_xfer = 0;
   int unsigned n_ovf = 0;
   int unsigned tb_ptr = 0;

   pb_cmd_arb #(
      .NUM_PB      (NUM_PB),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .PB       (PB),
      .cmd_rdy  (cmd_rdy),
      .cmd_vld  (cmd_vld),
      .cmd_id   (cmd_id),
      .cmd_long (cmd_long),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Press buttons in mask for n cycles, then release; queue the expected
   // commands in round-robin order from the model pointer.
   task automatic press(input logic [3:0] mask, input int n, input bit do_push);
      int unsigned base;
      int unsigned idx;
      bit          lng_exp;
      PB = PB & ~mask;
      tick(n);
      PB = PB | mask;
`ifdef PB_LONG_PRESS_EN
      lng_exp = (n >= int'(HOLD_CYCLES));
`else
      lng_exp = 1'b0;
`endif
      if (do_push) begin
         base = tb_ptr;
         for (int unsigned k = 0; k < NUM_PB; k++) begin
            idx = (base + k) % NUM_PB;
            if (mask[idx]) begin
               sb.push_back('{id: idx, lng: lng_exp});
               tb_ptr = (idx + 1) % NUM_PB;
            end
         end
      end
   endtask

   task automatic wait_vld(input string tag);
      int c = 0;
      while (!cmd_vld && c < 12) begin
         tick(1);
         c++;
      end
      check_eq(tag, 32'(cmd_vld), 1);
   endtask

   task automatic wait_drain(input int budget);
      int c = 0;
      while (sb.size() != 0 && c < budget) begin
         tick(1);
         c++;
      end
      check_eq("drain", sb.size(), 0);
      tick(2);
   endtask

   // Output monitor: pops on each transfer, checks stability under backpressure.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ovf) n_ovf++;
         if (cmd_vld) begin
            if (sb.size() == 0) begin
               check_eq("spurious_cmd", 1, 0);
            end else if (cmd_rdy) begin
               mon_e = sb.pop_front();
               check_eq("xfer_id", 32'(cmd_id), mon_e.id);
               check_eq("xfer_long", 32'(cmd_long), 32'(mon_e.lng));
               n_xfer++;
            end else begin
               check_eq("hold_id", 32'(cmd_id), sb[0].id);
            end
         end
      end
   end

   initial begin
      int unsigned sim_ids[3];
      int unsigned ovf0;
      int unsigned x0;
      int          c;
      sim_ids = '{0, 1, 3};

      // Reset and idle
      rst_n = 1'b0;
      PB = 4'hF;
      cmd_rdy = 1'b1;
      tick(2);
      check_eq("rst_vld", 32'(cmd_vld), 0);
      check_eq("rst_ovf", 32'(ovf), 0);
      check_eq("rst_long", 32'(cmd_long), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check_eq("idle_vld", 32'(cmd_vld), 0);
         check_eq("idle_ovf", 32'(ovf), 0);
         check_eq("idle_long", 32'(cmd_long), 0);
      end

      // Simultaneous releases of 0, 1, 3 from ptr=0
      press(4'b1011, 3, 1'b1);
      wait_vld("sim_vld_timeout");
      for (int j = 0; j < 3; j++) begin
         check_eq("sim_vld", 32'(cmd_vld), 1);
         check_eq("sim_id", 32'(cmd_id), sim_ids[j]);
         tick(1);
      end
      check_eq("sim_vld_end", 32'(cmd_vld), 0);
      wait_drain(10);

      // 0 and 3 together, ptr back at 0
      press(4'b1001, 3, 1'b1);
      wait_vld("pair_vld_timeout");
      check_eq("pair_id0", 32'(cmd_id), 0);
      tick(1);
      check_eq("pair_id1", 32'(cmd_id), 3);
      wait_drain(10);

      // Single release latency
      press(4'b0100, 3, 1'b1);
      c = 0;
      do begin
         tick(1);
         c++;
      end while (!cmd_vld && c < 10);
      check_eq("single_lat", 32'(c), 4);
      check_eq("single_id", 32'(cmd_id), 2);
      check_eq("single_long", 32'(cmd_long), 0);
      tick(1);
      check_eq("single_pulse", 32'(cmd_vld), 0);
      wait_drain(10);

      // Backpressure and overflow on button 1
      cmd_rdy = 1'b0;
      ovf0 = n_ovf;
      press(4'b0010, 3, 1'b1);
      tick(6);
      check_eq("bp_vld", 32'(cmd_vld), 1);
      check_eq("bp_id", 32'(cmd_id), 1);
      press(4'b0010, 3, 1'b1);
      tick(6);
      check_eq("bp_no_ovf", n_ovf - ovf0, 0);
      press(4'b0010, 3, 1'b0);
      tick(6);
      check_eq("bp_ovf", n_ovf - ovf0, 1);
      check_eq("bp_id_stable", 32'(cmd_id), 1);
      x0 = n_xfer;
      cmd_rdy = 1'b1;
      tick(8);
      check_eq("bp_delivered", n_xfer - x0, 2);
      check_eq("bp_sb_empty", sb.size(), 0);
      check_eq("bp_vld_end", 32'(cmd_vld), 0);

      // Long and short press
      press(4'b0010, 10, 1'b1);
      wait_drain(20);
      press(4'b0010, 5, 1'b1);
      wait_drain(20);

      // Reset mid-operation
      cmd_rdy = 1'b0;
      press(4'b0101, 3, 1'b1);
      tick(6);
      check_eq("mid_vld", 32'(cmd_vld), 1);
      check_eq("mid_pend", 32'(dut.pend), 32'(4'b0101 & ~(4'b0001 << sb[0].id)));
      rst_n = 1'b0;
      tick(1);
      check_eq("mid_rst_vld", 32'(cmd_vld), 0);
      check_eq("mid_rst_pend", 32'(dut.pend), 0);
      sb.delete();
      tb_ptr = 0;
      tick(1);
      rst_n = 1'b1;
      cmd_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check_eq("post_rst_vld", 32'(cmd_vld), 0);
      end

      check_eq("sb_final", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
